// File: rtl/flop_pipe_chain.sv
// Stallable DEPTH-stage, WIDTH-bit delay line with per-stage valid bits,
// synchronous reset to RESET_VAL, flush, hold, occupancy count and stage taps.
module flop_pipe_chain #(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              flush,
    input  logic                              in_valid,
    input  logic [WIDTH-1:0]                  D,
    output logic [WIDTH-1:0]                  Q,
    output logic                              out_valid,
    output logic [WIDTH*DEPTH-1:0]            taps,
    output logic [DEPTH-1:0]                  tap_valid,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Next valid vector; occupancy is its popcount so it tracks tap_valid exactly.
    always_comb begin
        valid_d = valid_q;
        occ_d   = '0;
        if (reset || flush) begin
            valid_d = '0;
        end else if (en) begin
            valid_d[0] = in_valid;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_d[i] = valid_q[i-1];
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        occ_q   <= occ_d;
    end

    // Data shifts on enable regardless of valid; flush leaves data untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= RESET_VAL;
            end
        end else if (!flush && en) begin
            data_q[0] <= D;
            for (int i = 1; i < int'(DEPTH); i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < int'(DEPTH); g++) begin : g_taps
            assign taps[g*WIDTH +: WIDTH] = data_q[g];
        end
    endgenerate

    assign Q         = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign tap_valid = valid_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_flop_pipe_chain.sv
// Directed self-checking bench for flop_pipe_chain (WIDTH=8, DEPTH=4, RESET_VAL=A5).
module tb_flop_pipe_chain;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   en = 1'b0;
    logic                   flush = 1'b0;
    logic                   in_valid = 1'b0;
    logic [WIDTH-1:0]       D = '0;
    logic [WIDTH-1:0]       Q;
    logic                   out_valid;
    logic [WIDTH*DEPTH-1:0] taps;
    logic [DEPTH-1:0]       tap_valid;
    logic [2:0]             occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    flop_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .D(D), .Q(Q), .out_valid(out_valid), .taps(taps),
        .tap_valid(tap_valid), .occupancy(occupancy)
    );

    always #30 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v, input logic [7:0] d);
        en = 1'b1; in_valid = v; D = d;
        step();
    endtask

    initial begin
        // 1: reset
        reset = 1'b1; en = 1'b1; in_valid = 1'b1; D = 8'h0F;
        step(); step();
        check("rst_q", 32'(Q), 32'hA5);
        check("rst_ov", 32'(out_valid), 32'h0);
        check("rst_occ", 32'(occupancy), 32'h0);
        check("rst_taps", taps, 32'hA5A5A5A5);
        check("rst_tv", 32'(tap_valid), 32'h0);
        reset = 1'b0;

        // 2: fill and stream
        for (int k = 1; k <= 5; k++) begin
            push(1'b1, 8'(k));
            check("fill_occ", 32'(occupancy), (k < 4) ? 32'(k) : 32'd4);
            if (k == 3) check("fill_ov3", 32'(out_valid), 32'h0);
            if (k == 4) begin
                check("fill_q4", 32'(Q), 32'h01);
                check("fill_ov4", 32'(out_valid), 32'h1);
            end
        end
        check("fill_q5", 32'(Q), 32'h02);
        check("fill_taps", taps, 32'h02030405);

        // 3: hold
        push(1'b1, 8'h06);
        check("pre_hold_q", 32'(Q), 32'h03);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            D = 8'hAA + 8'(k); in_valid = 1'b1;
            step();
            check("hold_taps", taps, 32'h03040506);
            check("hold_q", 32'(Q), 32'h03);
            check("hold_occ", 32'(occupancy), 32'h4);
        end
        push(1'b1, 8'h07);
        check("resume_q1", 32'(Q), 32'h04);
        push(1'b1, 8'h08);
        check("resume_q2", 32'(Q), 32'h05);
        check("resume_taps", taps, 32'h05060708);

        // 4: bubbles carry data
        push(1'b1, 8'h10);
        push(1'b0, 8'h11);
        push(1'b1, 8'h12);
        push(1'b0, 8'h13);
        check("bub_tv_a", 32'(tap_valid), 32'b1010);
        check("bub_occ_a", 32'(occupancy), 32'h2);
        check("bub_q_a", 32'(Q), 32'h10);
        push(1'b1, 8'h14);
        check("bub_tv_b", 32'(tap_valid), 32'b0101);
        check("bub_occ_b", 32'(occupancy), 32'h2);
        check("bub_q_b", 32'(Q), 32'h11);
        check("bub_ov_b", 32'(out_valid), 32'h0);

        // 5: flush beats enable
        for (int k = 0; k < 4; k++) push(1'b1, 8'h21 + 8'(k));
        check("pre_flush_occ", 32'(occupancy), 32'h4);
        flush = 1'b1; en = 1'b1; in_valid = 1'b1; D = 8'hFE;
        step();
        flush = 1'b0; en = 1'b0;
        check("flush_tv", 32'(tap_valid), 32'h0);
        check("flush_occ", 32'(occupancy), 32'h0);
        check("flush_taps", taps, 32'h21222324);
        check("flush_ov", 32'(out_valid), 32'h0);

        // 6: mid-stream reset then latency
        for (int k = 0; k < 4; k++) push(1'b1, 8'h31 + 8'(k));
        check("pre_rst_taps", taps, 32'h31323334);
        @(negedge clk);
        reset = 1'b1; en = 1'b1; in_valid = 1'b1; D = 8'h55;
        step();
        check("mrst_taps", taps, 32'hA5A5A5A5);
        check("mrst_tv", 32'(tap_valid), 32'h0);
        check("mrst_occ", 32'(occupancy), 32'h0);
        step();
        check("mrst_q", 32'(Q), 32'hA5);
        reset = 1'b0;
        push(1'b1, 8'h3C);
        check("lat_occ1", 32'(occupancy), 32'h1);
        for (int k = 2; k <= 4; k++) begin
            check("lat_ov_early", 32'(out_valid), 32'h0);
            push(1'b0, 8'h00);
        end
        check("lat_q", 32'(Q), 32'h3C);
        check("lat_ov", 32'(out_valid), 32'h1);
        check("lat_occ4", 32'(occupancy), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
